pipe_stage_reg: RTL



---
 rtl/pipe_stage_reg.sv | 97 +++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: advances, holds or bubbles a payload/control word
// under the shared stall vector and flush line, recirculates side state and counts bubble/flush cycles.
module pipe_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 16,
    parameter int SIDE_W     = 66,
    parameter int STALL_W    = 6,
    parameter int STAGE      = 3,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [STALL_W-1:0] stall,
    input  logic               in_valid,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SIDE_W-1:0]  side_i,
    output logic               out_valid,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_data,
    output logic [SIDE_W-1:0]  side_o,
    output logic               held,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic w_s_up;
    logic w_s_dn;

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic [SIDE_W-1:0] r_side;
    logic              r_held;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    assign w_s_up = stall[STAGE];
    assign w_s_dn = stall[STAGE+1];

    // NOTE: all state here is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_ctrl       <= '0;
            r_data       <= '0;
            r_side       <= '0;
            r_held       <= 1'b0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (flush) begin
            // Clearing side state makes the upstream restart a multi-cycle op from zero.
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_side  <= '0;
            r_held  <= 1'b0;
            if (CLEAR_DATA) begin
                r_data <= '0;
            end
            if (r_flush_cnt != '1) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end else if (w_s_up && !w_s_dn) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_side  <= side_i;
            r_held  <= 1'b0;
            if (CLEAR_DATA) begin
                r_data <= '0;
            end
            if (r_bubble_cnt != '1) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end else if (!w_s_up) begin
            // An illegal s_up=0/s_dn=1 combination also lands here and simply advances.
            r_valid <= in_valid;
            r_ctrl  <= in_valid ? in_ctrl : '0;
            r_data  <= in_data;
            r_side  <= '0;
            r_held  <= 1'b0;
        end else begin
            r_side <= side_i;
            r_held <= 1'b1;
        end
    end

    assign out_valid  = r_valid;
    assign out_ctrl   = r_ctrl;
    assign out_data   = r_data;
    assign side_o     = r_side;
    assign held       = r_held;
    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule
